// File: rtl/conversor_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds the FSM encoding, the add-3 threshold and a power-of-ten helper.
package conversor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGITS_DFLT = 4;
  localparam int         BCD_W       = 4 * DIGITS_DFLT;
  localparam logic [3:0] ADD3_THR    = 4'd5;

  // 10^n, used to check at elaboration that DIGITS covers the binary range.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/ajuste_bcd.sv
// Per-digit double-dabble correction: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module ajuste_bcd
  import conversor_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  // add-3 correction
  always_comb begin
    fixed = digit;
    if (digit >= ADD3_THR) begin
      fixed = digit + 4'd3;
    end else begin
      fixed = digit;
    end
  end

endmodule

// File: rtl/conversor_bin_bcd.sv
// Iterative binary-to-BCD converter (shift-add-3, one bit per clock)
// with valid/ready handshakes on input and output.
module conversor_bin_bcd
  import conversor_pkg::*;
#(
  parameter  int BIN_W  = 13,
  parameter  int DIGITS = DIGITS_DFLT,
  localparam int CNT_W  = $clog2(BIN_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int SR_W  = ACC_W + BIN_W;

  if (((64'd1 << BIN_W) - 64'd1) > (pow10(DIGITS) - 64'd1)) begin : g_digits_too_few
    $error("conversor_bin_bcd: DIGITS too small for BIN_W");
  end

  state_t            state_r;
  state_t            state_s;
  logic [SR_W-1:0]   sr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ACC_W-1:0]  acc_fix_s;
  logic [SR_W-1:0]   sr_shift_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    ajuste_bcd u_adj (
      .digit (sr_r[BIN_W + 4*g +: 4]),
      .fixed (acc_fix_s[4*g +: 4])
    );
  end

  // Binary MSB moves into accumulator bit 0 after the digit corrections.
  assign sr_shift_s = {acc_fix_s, sr_r[BIN_W-1:0]} << 1;

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = SHIFT;
        else          state_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(1)) state_s = DONE;
        else                    state_s = SHIFT;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // state register and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      busy      <= (state_s == SHIFT);
      out_valid <= (state_s == DONE);
    end
  end

  // shift register, bit counter and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r    <= '0;
      cnt_r   <= '0;
      bcd_out <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sr_r  <= {{ACC_W{1'b0}}, bin_in};
            cnt_r <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          sr_r  <= sr_shift_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            bcd_out <= sr_shift_s[SR_W-1 -: ACC_W];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Self-checking bench for conversor_bin_bcd: directed table, corner-case
// sequences and random values checked against a decimal-arithmetic model.
module tb_conversor_bin_bcd;
  import conversor_pkg::*;

  localparam int BIN_W = 13;

  logic             clk;
  logic             rst;
  logic [BIN_W-1:0] bin_in;
  logic             in_valid;
  logic             in_ready;
  logic [BCD_W-1:0] bcd_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    logic [BIN_W-1:0] bin;
    logic [BCD_W-1:0] bcd;
  } vec_t;

  vec_t tbl[5];

  conversor_bin_bcd #(.BIN_W(BIN_W), .DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits via division, no shifting involved.
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Counts negedges until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
  endtask

  task automatic do_conv(input logic [BIN_W-1:0] v, input logic [BCD_W-1:0] exp, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    out_ready = (hold == 0);
    bin_in    = v;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    bin_in    = ~v;
    chk("busy_in_shift", 32'(busy), 32'd1);
    wait_valid(n);
    chk("latency", 32'(n), 32'(BIN_W));
    chk("bcd_out", 32'(bcd_out), 32'(exp));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_stable", {15'd0, out_valid, in_ready, bcd_out}, {15'd0, 1'b1, 1'b0, exp});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("back_to_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    int n;
    tbl[0] = '{bin: 13'd0,    bcd: 16'h0000};
    tbl[1] = '{bin: 13'd1998, bcd: 16'h1998};
    tbl[2] = '{bin: 13'd8190, bcd: 16'h8190};
    tbl[3] = '{bin: 13'd8191, bcd: 16'h8191};
    tbl[4] = '{bin: 13'd9,    bcd: 16'h0009};

    rst = 1'b0; bin_in = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {14'd0, in_ready, out_valid, busy, bcd_out[0], bcd_out},
        {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) do_conv(tbl[i].bin, tbl[i].bcd, 0);

    do_conv(13'd4321, 16'h4321, 20);

    // in_valid held while bin_in changes mid-conversion
    bin_in = 13'd1234; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    bin_in = 13'd5678;
    wait_valid(n);
    chk("held_latency", 32'(n), 32'(BIN_W));
    chk("held_first", 32'(bcd_out), 32'h1234);
    wait_valid(n);
    in_valid = 1'b0;
    chk("held_spacing", 32'(n), 32'(BIN_W + 2));
    chk("held_second", 32'(bcd_out), 32'h5678);
    @(negedge clk);

    // asynchronous reset in the middle of a conversion
    bin_in = 13'd777; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("mid_reset", {14'd0, in_ready, out_valid, busy, 1'b0, bcd_out},
           {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("no_emit_after_reset", 32'(out_valid), 32'd0);
    do_conv(13'd42, 16'h0042, 0);

    // back-to-back with in_valid permanently high
    bin_in = 13'd100; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    wait_valid(n);
    chk("b2b_first", 32'(bcd_out), 32'h0100);
    bin_in = 13'd200;
    wait_valid(n);
    in_valid = 1'b0;
    chk("b2b_spacing", 32'(n), 32'(BIN_W + 2));
    chk("b2b_second", 32'(bcd_out), 32'h0200);
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      int v;
      v = int'($urandom_range(8191, 0));
      do_conv(13'(v), to_bcd(v), int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
